// File: rtl/cache_maint_seq.sv
// cache_maint_seq: walks every cache line to run a maintenance command.
//   CLEAR (3'b001) invalidates all lines. WB (3'b010) writes back every
//   valid and dirty line, then marks it clean. Any other code completes
//   at once without touching the tag RAM.
// Optional macro CACHE_CLEAR_WRITEBACK_EN: when defined, CLEAR writes back a
//   valid and dirty line before invalidating it. When undefined, CLEAR drops
//   the dirty data and never raises wb_req.
// All strobes are decoded from the state register. Addresses come from the
//   idx register, gated by state. Each output is therefore glitch-free and
//   reads 0 as soon as reset is applied.
module cache_maint_seq #(
  parameter int LINE_NUM = 64,
  localparam int IW = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1
) (
  input  logic          clk,
  input  logic          rest,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic          busy,
  output logic [IW-1:0] tag_addr,
  output logic          tag_rd,
  input  logic          tag_rdValid,
  input  logic          tag_rdDirty,
  output logic          tag_wr,
  output logic          tag_wrValid,
  output logic          tag_wrDirty,
  output logic          wb_req,
  output logic [IW-1:0] wb_index,
  input  logic          wb_ack
);

  localparam logic [2:0]    CMD_CLEAR = 3'b001;
  localparam logic [2:0]    CMD_WB    = 3'b010;
  localparam logic [IW-1:0] LAST_IDX  = IW'(LINE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WBACK,
    UPDATE,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [2:0]    cmd_reg, cmd_next;
  logic          is_wb;
  logic          line_dirty;

  assign is_wb      = (cmd_reg == CMD_WB);
  assign line_dirty = tag_rdValid & tag_rdDirty;

  // State, line index and captured command registers.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cmd_reg   <= 3'b000;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cmd_reg   <= cmd_next;
    end
  end

  // Next-state logic. Stepping past the last line ends the walk. This keeps
  // idx from ever wrapping during a command.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cmd_next   = cmd_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          cmd_next = cmd;
          idx_next = '0;
          if ((cmd == CMD_CLEAR) || (cmd == CMD_WB)) begin
            state_next = READ;
          end else begin
            state_next = DONE;
          end
        end
      end
      READ: begin
        state_next = CHECK;
      end
      CHECK: begin
        if (is_wb) begin
          if (line_dirty) begin
            state_next = WBACK;
          end else if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + IW'(1);
            state_next = READ;
          end
        end else begin
`ifdef CACHE_CLEAR_WRITEBACK_EN
          state_next = line_dirty ? WBACK : UPDATE;
`else
          state_next = UPDATE;
`endif
        end
      end
      WBACK: begin
        if (wb_ack) begin
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + IW'(1);
          state_next = READ;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register. Addresses read zero outside
  // the states that use them.
  always_comb begin
    busy        = (state_reg != IDLE);
    cmd_ready   = (state_reg == DONE);
    tag_rd      = (state_reg == READ);
    tag_wr      = (state_reg == UPDATE);
    wb_req      = (state_reg == WBACK);
    tag_addr    = (tag_rd || tag_wr) ? idx_reg : '0;
    wb_index    = wb_req ? idx_reg : '0;
    tag_wrValid = tag_wr & is_wb;
    tag_wrDirty = 1'b0;
  end

endmodule

// File: tb/tb_cache_maint_seq.sv
// Directed bench for cache_maint_seq with LINE_NUM=4. A small tag RAM model
// answers reads one cycle late. A write-back responder acks after a
// programmable delay. A negedge monitor stores, for each cycle counted from
// command acceptance (cycle 0), which strobes were active and their
// addresses. Each test compares those bitmasks with hand-computed values.
module tb_cache_maint_seq;

  localparam int LN = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rest = 1'b0;
  logic [2:0]    cmd = 3'b000;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready, busy, tag_rd, tag_wr, tag_wrValid, tag_wrDirty, wb_req;
  logic [IW-1:0] tag_addr, wb_index;
  logic          tag_rdValid = 1'b0;
  logic          tag_rdDirty = 1'b0;
  logic          wb_ack;

  int tests = 0;
  int fails = 0;

  cache_maint_seq #(.LINE_NUM(LN)) dut (
    .clk(clk), .rest(rest), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .tag_addr(tag_addr), .tag_rd(tag_rd),
    .tag_rdValid(tag_rdValid), .tag_rdDirty(tag_rdDirty), .tag_wr(tag_wr),
    .tag_wrValid(tag_wrValid), .tag_wrDirty(tag_wrDirty), .wb_req(wb_req),
    .wb_index(wb_index), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Tag RAM model: reads return one cycle later, and a preload overrides writes.
  logic [3:0] mv = 4'h0, md = 4'h0, load_v = 4'h0, load_d = 4'h0;
  logic       load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      mv <= load_v;
      md <= load_d;
    end else if (tag_wr) begin
      mv[tag_addr] <= tag_wrValid;
      md[tag_addr] <= tag_wrDirty;
    end
    if (tag_rd) begin
      tag_rdValid <= mv[tag_addr];
      tag_rdDirty <= md[tag_addr];
    end
  end

  // Write-back responder: acks once wb_req has been high for ack_delay cycles.
  int ack_delay = 0;
  int wb_cnt = 0;
  always @(posedge clk) begin
    if (wb_req && !wb_ack) wb_cnt <= wb_cnt + 1;
    else wb_cnt <= 0;
  end
  assign wb_ack = wb_req && (wb_cnt >= ack_delay);

  // Per-cycle trace, indexed by the cycle offset from acceptance.
  int          t0 = 1 << 30;
  int          rel;
  logic [63:0] rd_m = '0, wr_m = '0, wb_m = '0, rdy_m = '0, busy_m = '0;
  logic [1:0]  addr_at [64];
  logic [1:0]  wbi_at [64];
  logic        wv_at [64];
  logic        wd_at [64];
  int          conflicts = 0;
  always @(negedge clk) begin
    rel = cyc_cnt - t0;
    if (rel == 0) begin
      rd_m = '0; wr_m = '0; wb_m = '0; rdy_m = '0; busy_m = '0;
    end
    if (rel >= 0 && rel < 64) begin
      rd_m[rel]   = tag_rd;
      wr_m[rel]   = tag_wr;
      wb_m[rel]   = wb_req;
      rdy_m[rel]  = cmd_ready;
      busy_m[rel] = busy;
      addr_at[rel] = tag_addr;
      wbi_at[rel]  = wb_index;
      wv_at[rel]   = tag_wrValid;
      wd_at[rel]   = tag_wrDirty;
    end
    if (int'(tag_rd) + int'(tag_wr) + int'(wb_req) > 1) conflicts++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [3:0] v, input logic [3:0] d);
    @(posedge clk); #1;
    load_v = v; load_d = d; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Issues a command, holds cmd_valid through the cmd_ready cycle, then
  // idles a few cycles so that the trace also covers the cycles after it.
  task automatic run_cmd(input logic [2:0] c, output logic seen);
    seen = 1'b0;
    @(posedge clk); #1;
    cmd = c; cmd_valid = 1'b1; t0 = cyc_cnt;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = 3'b000;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); fails++; end
    tests++;
    if (cmd_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", cmd_ready); fails++; end
    tests++;
    if ({tag_rd, tag_wr, wb_req} !== 3'b000) begin
      $display("FAIL reset_strobes: got %b want 000", {tag_rd, tag_wr, wb_req}); fails++;
    end
    tests++;
    if ({tag_addr, wb_index} !== 4'h0) begin
      $display("FAIL reset_addr: got %h want 0", {tag_addr, wb_index}); fails++;
    end
    rest = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wb_clean();
    logic seen;
    preload(4'hF, 4'h0);
    run_cmd(3'b010, seen);
    tests++;
    if (!seen) begin $display("FAIL wb_clean_ready: cmd_ready not seen within 200 cycles"); fails++; end
    tests++;
    if (rd_m !== 64'hAA) begin $display("FAIL wb_clean_rd: got %h want %h", rd_m, 64'hAA); fails++; end
    tests++;
    if ((wr_m | wb_m) !== 64'h0) begin $display("FAIL wb_clean_wr_wb: got %h want 0", wr_m | wb_m); fails++; end
    tests++;
    if (rdy_m !== 64'h200) begin $display("FAIL wb_clean_rdy: got %h want %h", rdy_m, 64'h200); fails++; end
    tests++;
    if (busy_m !== 64'h3FE) begin $display("FAIL wb_clean_busy: got %h want %h", busy_m, 64'h3FE); fails++; end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (addr_at[2*i+1] !== 2'(i)) begin
        $display("FAIL wb_clean_addr%0d: got %0d want %0d", i, addr_at[2*i+1], i); fails++;
      end
    end
  endtask

  task automatic test_wb_dirty();
    logic seen;
    ack_delay = 2;
    preload(4'hF, 4'b0100);
    run_cmd(3'b010, seen);
    tests++;
    if (!seen) begin $display("FAIL wb_dirty_ready: cmd_ready not seen within 200 cycles"); fails++; end
    tests++;
    if (rd_m !== 64'h82A) begin $display("FAIL wb_dirty_rd: got %h want %h", rd_m, 64'h82A); fails++; end
    tests++;
    if (wb_m !== 64'h380) begin $display("FAIL wb_dirty_wb: got %h want %h", wb_m, 64'h380); fails++; end
    for (int c = 7; c <= 9; c++) begin
      tests++;
      if (wbi_at[c] !== 2'd2) begin $display("FAIL wb_dirty_index_c%0d: got %0d want 2", c, wbi_at[c]); fails++; end
    end
    tests++;
    if (wr_m !== 64'h400) begin $display("FAIL wb_dirty_wr: got %h want %h", wr_m, 64'h400); fails++; end
    tests++;
    if ({addr_at[10], wv_at[10], wd_at[10]} !== 4'b1010) begin
      $display("FAIL wb_dirty_wrdata: got %b want 1010", {addr_at[10], wv_at[10], wd_at[10]}); fails++;
    end
    tests++;
    if (rdy_m !== 64'h2000) begin $display("FAIL wb_dirty_rdy: got %h want %h", rdy_m, 64'h2000); fails++; end
    tests++;
    if (busy_m !== 64'h3FFE) begin $display("FAIL wb_dirty_busy: got %h want %h", busy_m, 64'h3FFE); fails++; end
    tests++;
    if ({mv, md} !== 8'hF0) begin $display("FAIL wb_dirty_tags: got %h want F0", {mv, md}); fails++; end
  endtask

  task automatic test_clear();
    logic seen;
    int wc[4];
    ack_delay = 0;
    preload(4'hF, 4'b1010);
    run_cmd(3'b001, seen);
    tests++;
    if (!seen) begin $display("FAIL clear_ready: cmd_ready not seen within 200 cycles"); fails++; end
`ifdef CACHE_CLEAR_WRITEBACK_EN
    wc = '{3, 7, 10, 14};
    tests++;
    if (rd_m !== 64'h912) begin $display("FAIL clear_rd: got %h want %h", rd_m, 64'h912); fails++; end
    tests++;
    if (wb_m !== 64'h2040) begin $display("FAIL clear_wb: got %h want %h", wb_m, 64'h2040); fails++; end
    tests++;
    if ({wbi_at[6], wbi_at[13]} !== 4'b0111) begin
      $display("FAIL clear_wb_index: got %b want 0111", {wbi_at[6], wbi_at[13]}); fails++;
    end
    tests++;
    if (wr_m !== 64'h4488) begin $display("FAIL clear_wr: got %h want %h", wr_m, 64'h4488); fails++; end
    tests++;
    if (rdy_m !== 64'h8000) begin $display("FAIL clear_rdy: got %h want %h", rdy_m, 64'h8000); fails++; end
`else
    wc = '{3, 6, 9, 12};
    tests++;
    if (rd_m !== 64'h492) begin $display("FAIL clear_rd: got %h want %h", rd_m, 64'h492); fails++; end
    tests++;
    if (wb_m !== 64'h0) begin $display("FAIL clear_wb: got %h want 0", wb_m); fails++; end
    tests++;
    if (wr_m !== 64'h1248) begin $display("FAIL clear_wr: got %h want %h", wr_m, 64'h1248); fails++; end
    tests++;
    if (rdy_m !== 64'h2000) begin $display("FAIL clear_rdy: got %h want %h", rdy_m, 64'h2000); fails++; end
`endif
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({addr_at[wc[i]], wv_at[wc[i]], wd_at[wc[i]]} !== {2'(i), 2'b00}) begin
        $display("FAIL clear_wr%0d: got %b want %b", i,
                 {addr_at[wc[i]], wv_at[wc[i]], wd_at[wc[i]]}, {2'(i), 2'b00});
        fails++;
      end
    end
    tests++;
    if ({mv, md} !== 8'h00) begin $display("FAIL clear_tags: got %h want 00", {mv, md}); fails++; end
  endtask

  task automatic test_nop();
    logic seen;
    run_cmd(3'b111, seen);
    tests++;
    if (!seen) begin $display("FAIL nop_ready: cmd_ready not seen within 200 cycles"); fails++; end
    tests++;
    if (rdy_m !== 64'h2) begin $display("FAIL nop_rdy: got %h want 2", rdy_m); fails++; end
    tests++;
    if (busy_m !== 64'h2) begin $display("FAIL nop_busy: got %h want 2", busy_m); fails++; end
    tests++;
    if ((rd_m | wr_m | wb_m) !== 64'h0) begin
      $display("FAIL nop_tag_access: got %h want 0", rd_m | wr_m | wb_m); fails++;
    end
  endtask

  task automatic test_reset_midwalk();
    logic seen;
    logic hit;
    ack_delay = 100;
    preload(4'hF, 4'b0010);
    hit = 1'b0;
    @(posedge clk); #1;
    cmd = 3'b010; cmd_valid = 1'b1; t0 = cyc_cnt;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wb_req === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    tests++;
    if (!hit || wb_index !== 2'd1) begin
      $display("FAIL midwalk_reach_wback: got hit=%b index=%0d want hit=1 index=1", hit, wb_index); fails++;
    end
    rest = 1'b0;
    cmd_valid = 1'b0; cmd = 3'b000;
    #1;
    tests++;
    if ({busy, cmd_ready, tag_rd, tag_wr, wb_req, tag_addr, wb_index} !== 9'h0) begin
      $display("FAIL midwalk_reset_outputs: got %h want 0",
               {busy, cmd_ready, tag_rd, tag_wr, wb_req, tag_addr, wb_index});
      fails++;
    end
    repeat (2) @(posedge clk);
    #2;
    rest = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (rdy_m !== 64'h0) begin $display("FAIL midwalk_no_ready: got %h want 0", rdy_m); fails++; end
    ack_delay = 0;
    run_cmd(3'b010, seen);
    tests++;
    if (!seen) begin $display("FAIL restart_ready: cmd_ready not seen within 200 cycles"); fails++; end
    tests++;
    if (rd_m !== 64'h28A) begin $display("FAIL restart_rd: got %h want %h", rd_m, 64'h28A); fails++; end
    tests++;
    if (wb_m !== 64'h20 || wbi_at[5] !== 2'd1) begin
      $display("FAIL restart_wb: got %h idx %0d want 20 idx 1", wb_m, wbi_at[5]); fails++;
    end
    tests++;
    if (wr_m !== 64'h40 || addr_at[6] !== 2'd1) begin
      $display("FAIL restart_wr: got %h addr %0d want 40 addr 1", wr_m, addr_at[6]); fails++;
    end
    tests++;
    if (rdy_m !== 64'h800) begin $display("FAIL restart_rdy: got %h want %h", rdy_m, 64'h800); fails++; end
  endtask

  task automatic test_exclusive_strobes();
    tests++;
    if (conflicts !== 0) begin
      $display("FAIL exclusive_strobes: got %0d overlapping cycles want 0", conflicts); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_wb_clean();
    test_wb_dirty();
    test_clear();
    test_nop();
    test_reset_midwalk();
    test_exclusive_strobes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
